imm_field_encoder: RTL and testbench

- Streaming encoder that takes a base instruction word, an immediate format selector and a 32-bit immediate value, and produces the complete RV32 instruction word with the immediate scattered into the I/S/B/J bit positions.
- Used by the self-test instruction stream generator and the boot-image patcher to build instructions for the pipelined core.
- Valid/ready on both sides, one register stage, then an output FIFO.

---
 rtl/imm_enc_pkg.sv | 60 ++++++
 rtl/imm_enc_fifo.sv | 54 +++++
 rtl/imm_field_encoder.sv | 89 ++++++++
 tb/tb_imm_field_encoder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_enc_pkg.sv
// Shared immediate-format types, limits and the field-scatter helper for imm_field_encoder.
// The range-check helper is only referenced when IMM_ENC_RANGE_CHECK_EN is defined.
package imm_enc_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_fmt_e;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  localparam int signed IS_MIN = -2048;
  localparam int signed IS_MAX = 2047;
  localparam int signed B_MIN  = -4096;
  localparam int signed B_MAX  = 4094;
  localparam int signed J_MIN  = -1048576;
  localparam int signed J_MAX  = 1048574;

  // Overwrites only the immediate bit positions of the base word.
  function automatic logic [31:0] pack_imm(input logic [31:0] base,
                                           input imm_fmt_e    fmt,
                                           input logic [31:0] imm);
    logic [31:0] r;
    r = base;
    case (fmt)
      IMM_I: r[31:20] = imm[11:0];
      IMM_S: begin
        r[31:25] = imm[11:5];
        r[11:7]  = imm[4:0];
      end
      IMM_B: begin
        r[31]    = imm[12];
        r[7]     = imm[11];
        r[30:25] = imm[10:5];
        r[11:8]  = imm[4:1];
      end
      default: begin
        r[31]    = imm[20];
        r[19:12] = imm[19:12];
        r[20]    = imm[11];
        r[30:21] = imm[10:1];
      end
    endcase
    return r;
  endfunction

  function automatic logic imm_out_of_range(input imm_fmt_e    fmt,
                                            input logic [31:0] imm);
    logic signed [31:0] v;
    v = $signed(imm);
    case (fmt)
      IMM_I, IMM_S: return (v < IS_MIN) || (v > IS_MAX);
      IMM_B:        return (v < B_MIN) || (v > B_MAX) || imm[0];
      default:      return (v < J_MIN) || (v > J_MAX) || imm[0];
    endcase
  endfunction

endpackage

// File: rtl/imm_enc_fifo.sv
// Synchronous FIFO with async active-low reset; head reads as zero while empty.
module imm_enc_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // When full, a same-cycle pop frees the slot being written.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/imm_field_encoder.sv
// Streaming RV32 immediate encoder: one register stage feeding an output FIFO.
// Define IMM_ENC_RANGE_CHECK_EN to flag unrepresentable immediates (NOP + out_err).
module imm_field_encoder
  import imm_enc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_imm_src,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count
);

  localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FCW-1:0] FULL_CNT = FCW'(FIFO_DEPTH);

  logic           s1_valid;
  logic [31:0]    s1_instr;
  logic           s1_err;
  logic [31:0]    next_instr;
  logic           next_err;
  logic           pop;
  logic           push_ok;
  logic           s1_push;
  logic           fifo_empty;
  logic [FCW-1:0] fifo_count;
  logic [32:0]    fifo_dout;

  assign pop      = out_valid && out_ready;
  assign push_ok  = (fifo_count < FULL_CNT) || pop;
  assign s1_push  = s1_valid && push_ok;
  assign in_ready = !s1_valid || push_ok;

  always_comb begin
    next_instr = pack_imm(in_base, imm_fmt_e'(in_imm_src), in_imm);
    next_err   = 1'b0;
`ifdef IMM_ENC_RANGE_CHECK_EN
    next_err = imm_out_of_range(imm_fmt_e'(in_imm_src), in_imm);
    if (next_err) next_instr = NOP_INSTR;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_instr <= '0;
      s1_err   <= 1'b0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_instr <= next_instr;
      s1_err   <= next_err;
    end else if (s1_push) begin
      s1_valid <= 1'b0;
    end
  end

  imm_enc_fifo #(
    .WIDTH(33),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s1_push),
    .din   ({s1_err, s1_instr}),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_instr = fifo_dout[31:0];
  assign out_err   = fifo_dout[32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   enc_count <= '0;
    else if (pop) enc_count <= enc_count + 1'b1;
  end

endmodule

// File: tb/tb_imm_field_encoder.sv
// Scoreboard bench for imm_field_encoder: expected beats queued at input transfer, checked at pop.
module tb_imm_field_encoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 16;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_imm_src;
  logic [31:0]   in_imm;
  logic [31:0]   in_base;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic          out_err;
  logic [CW-1:0] enc_count;

  imm_field_encoder #(
    .FIFO_DEPTH(DEPTH),
    .CNT_W(CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_imm_src (in_imm_src),
    .in_imm     (in_imm),
    .in_base    (in_base),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_err    (out_err),
    .enc_count  (enc_count)
  );

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [1:0]  src;
    logic [31:0] imm;
    int          acc_cyc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   model_cnt = 0;
  bit   accepted;
  bit   rand_ready = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] decode_imm(input logic [31:0] w, input logic [1:0] src);
    case (src)
      2'b00:   return {{20{w[31]}}, w[31:20]};
      2'b01:   return {{20{w[31]}}, w[31:25], w[11:7]};
      2'b10:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] base, input logic [1:0] src, input logic [31:0] imm);
    exp_t e;
    e.src = src; e.imm = imm; e.err = 1'b0; e.acc_cyc = 0; e.lat = 1'b0;
    case (src)
      2'b00:   e.instr = {imm[11:0], base[19:0]};
      2'b01:   e.instr = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
      2'b10:   e.instr = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
      default: e.instr = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
    endcase
`ifdef IMM_ENC_RANGE_CHECK_EN
    case (src)
      2'b00, 2'b01: e.err = ($signed(imm) < -2048) || ($signed(imm) > 2047);
      2'b10:        e.err = ($signed(imm) < -4096) || ($signed(imm) > 4094) || imm[0];
      default:      e.err = ($signed(imm) < -1048576) || ($signed(imm) > 1048574) || imm[0];
    endcase
    if (e.err) e.instr = 32'h00000013;
`endif
    return e;
  endfunction

  function automatic logic [31:0] rand_imm(input logic [1:0] src);
    case (src)
      2'b00, 2'b01: return 32'($signed($urandom_range(0, 4095)) - 2048);
      2'b10:        return 32'($signed($urandom_range(0, 4095)) * 2 - 4096);
      default:      return 32'($signed($urandom_range(0, 1048575)) * 2 - 1048576);
    endcase
  endfunction

  // One clock: check head/pop and record transfer at negedge, then advance past posedge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    accepted = 1'b0;
    if (out_valid) begin
      check_eq("sb_nonempty", (sb.size() > 0) ? 1 : 0, 1);
      if (sb.size() > 0) begin
        e = sb[0];
        check_eq("head_instr", out_instr, e.instr);
        check_eq("head_err", out_err, e.err);
        if (out_ready) begin
          void'(sb.pop_front());
          check_eq("enc_count", enc_count, model_cnt);
          model_cnt++;
          if (!e.err) check_eq("round_trip", decode_imm(out_instr, e.src), e.imm);
          if (e.lat) check_eq("latency", cyc - e.acc_cyc, 2);
        end
      end
    end
    if (in_valid && in_ready) begin
      cur.acc_cyc = cyc;
      sb.push_back(cur);
      accepted = 1'b1;
    end
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [31:0] base, input logic [1:0] src, input logic [31:0] imm,
                      input bit lat, input bit use_k, input logic [31:0] k_instr, input logic k_err);
    int n;
    cur = model(base, src, imm);
    cur.lat = lat;
    if (use_k) begin
      cur.instr = k_instr;
      cur.err   = k_err;
    end
    in_base = base; in_imm_src = src; in_imm = imm; in_valid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!accepted && n < 100);
    if (!accepted) check_eq("send_accept", accepted, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      step();
      n++;
    end
    if (sb.size() > 0) check_eq("drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int n;
    int base_cnt;
    logic [31:0] bp_base [8];
    logic [1:0]  bp_src  [8];
    logic [31:0] bp_imm  [8];

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_imm_src = '0; in_imm = '0; in_base = '0;
    #12;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_instr", out_instr, 0);
    check_eq("rst_out_err", out_err, 0);
    check_eq("rst_enc_count", enc_count, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(32'h00000093, 2'b00, 32'hFFFFFFFF, 1, 1, 32'hFFF00093, 1'b0);
    drain();
    check_eq("enc_count_i", enc_count, 1);
    send(32'h00002023, 2'b01, 32'h000007F4, 1, 1, 32'h7E002A23, 1'b0);
    drain();
    send(32'h00000063, 2'b10, 32'hFFFFFFFC, 1, 1, 32'hFE000EE3, 1'b0);
    drain();
    send(32'h000000EF, 2'b11, 32'h00000800, 1, 1, 32'h001000EF, 1'b0);
    drain();
`ifdef IMM_ENC_RANGE_CHECK_EN
    send(32'h00000063, 2'b10, 32'h00000003, 0, 1, 32'h00000013, 1'b1);
    send(32'h000000EF, 2'b11, 32'h00100000, 0, 1, 32'h00000013, 1'b1);
    send(32'h00000093, 2'b00, 32'h00000800, 0, 1, 32'h00000013, 1'b1);
    send(32'h00002023, 2'b01, 32'hFFFFF7FF, 0, 1, 32'h00000013, 1'b1);
    drain();
`endif

    // Random stream with random backpressure.
    rand_ready = 1;
    for (int i = 0; i < 150; i++) begin
      logic [1:0] s;
      s = 2'($urandom_range(0, 3));
      send($urandom, s, rand_imm(s), 0, 0, '0, 1'b0);
    end
    rand_ready = 0;
    out_ready = 1'b1;
    drain();

    // Full-FIFO backpressure.
    for (int i = 0; i < 8; i++) begin
      bp_base[i] = $urandom;
      bp_src[i]  = 2'(i % 4);
      bp_imm[i]  = rand_imm(bp_src[i]);
    end
    base_cnt = model_cnt;
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 12 && idx < 8; c++) begin
      cur = model(bp_base[idx], bp_src[idx], bp_imm[idx]);
      in_base = bp_base[idx]; in_imm_src = bp_src[idx]; in_imm = bp_imm[idx]; in_valid = 1'b1;
      step();
      if (accepted) idx++;
    end
    check_eq("bp_accepted", idx, 5);
    check_eq("bp_in_ready", in_ready, 0);
    out_ready = 1'b1;
    n = 0;
    while (idx < 8 && n < 50) begin
      cur = model(bp_base[idx], bp_src[idx], bp_imm[idx]);
      in_base = bp_base[idx]; in_imm_src = bp_src[idx]; in_imm = bp_imm[idx]; in_valid = 1'b1;
      step();
      if (accepted) idx++;
      n++;
    end
    in_valid = 1'b0;
    check_eq("bp_all_sent", idx, 8);
    drain();
    check_eq("bp_enc_count", enc_count, base_cnt + 8);

    // Reset with beats in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h00000013, 2'b00, 32'(i + 1), 0, 0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_enc_count", enc_count, 0);
    check_eq("mid_rst_in_ready", in_ready, 1);
    check_eq("mid_rst_out_err", out_err, 0);
    sb.delete();
    model_cnt = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h00000093, 2'b00, 32'h00000005, 1, 1, 32'h00500093, 1'b0);
    drain();
    check_eq("post_rst_enc_count", enc_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
